// File: rtl/servo_pwm_gen.sv
// Four-channel servo PWM generator: a microsecond prescaler drives a period counter,
// and per-channel high-times/enables are shadowed at each period wrap so pulses never glitch.
module servo_pwm_gen #(
  parameter int CLK_DIV = 48,
  parameter int PERIOD  = 20000
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [15:0] servo_pwm0_high,
  input  logic [15:0] servo_pwm1_high,
  input  logic [15:0] servo_pwm2_high,
  input  logic [15:0] servo_pwm3_high,
  input  logic [3:0]  servo_en,
  output logic [3:0]  SERVO_OUT,
  output logic        frame_sync
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [15:0]   PCNT_MAX  = 16'(PERIOD - 1);

  logic [PW-1:0] presc;
  logic [15:0]   pcnt;
  logic [15:0]   hi_sh [4];
  logic [3:0]    en_sh;
  logic [15:0]   hi_in [4];
  logic [3:0]    cmp;
  logic          tick;
  logic          wrap;

  assign hi_in[0] = servo_pwm0_high;
  assign hi_in[1] = servo_pwm1_high;
  assign hi_in[2] = servo_pwm2_high;
  assign hi_in[3] = servo_pwm3_high;

  assign tick = (presc == PRESC_MAX);
  assign wrap = tick && (pcnt == PCNT_MAX);

  always_comb begin
    cmp = '0;
    for (int n = 0; n < 4; n++) begin
      cmp[n] = (pcnt < hi_sh[n]);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        pcnt <= wrap ? 16'd0 : pcnt + 16'd1;
      end
    end
  end

  // Shadows change only on the wrap cycle, so the new values govern the whole next period.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      for (int n = 0; n < 4; n++) begin
        hi_sh[n] <= '0;
      end
      en_sh <= '0;
    end else if (wrap) begin
      for (int n = 0; n < 4; n++) begin
        hi_sh[n] <= hi_in[n];
      end
      en_sh <= servo_en;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      SERVO_OUT  <= '0;
      frame_sync <= 1'b0;
    end else begin
      SERVO_OUT  <= en_sh & cmp;
      frame_sync <= wrap;
    end
  end

endmodule
